// File: rtl/wall_datapath_if.sv
// wall_vga_if: pixel write bus from the wall datapath to the VGA adapter
//   x_out  [7:0] pixel x
//   y_out  [6:0] pixel y
//   colour [2:0] pixel colour
//   plot         pixel write strobe, one pixel per cycle
interface wall_vga_if;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;
    modport master (output x_out, y_out, colour, plot);
    modport slave  (input  x_out, y_out, colour, plot);
endinterface

// File: rtl/wall_datapath.sv
// wall_datapath: wall position, pixel sweeps that erase/draw the wall, and the touched flag for the wall FSM
//   clk       system clock
//   reset     asynchronous active-high reset
//   state     FSM state code (READY/MOVE/STOP/DRAW/DEL/UPDATE)
//   player_x  player box left x
//   player_y  player box top y
//   vga       pixel bus to the VGA adapter (wall_vga_if.master)
//   touched   sticky collision / left-edge flag
//   busy      sweep running or one queued
module wall_datapath #(
    parameter int         START_X  = 150,
    parameter int         WALL_Y   = 60,
    parameter int         WALL_W   = 4,
    parameter int         WALL_H   = 40,
    parameter int         STEP     = 1,
    parameter int         MOVE_DIV = 4,
    parameter int         PLAYER_W = 4,
    parameter int         PLAYER_H = 4,
    parameter logic [2:0] WALL_COL = 3'b111,
    parameter logic [2:0] BG_COL   = 3'b000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       state,
    input  logic [7:0]       player_x,
    input  logic [6:0]       player_y,
    wall_vga_if.master       vga,
    output logic             touched,
    output logic             busy
);
    localparam logic [3:0] ST_READY = 4'b0101;
    localparam logic [3:0] ST_MOVE  = 4'b0110;
    localparam logic [3:0] ST_DRAW  = 4'b1000;
    localparam logic [3:0] ST_DEL   = 4'b1001;

    typedef enum logic {S_IDLE, S_RUN} sweep_t;

    sweep_t     sw_q, sw_d;
    logic [3:0] prev_state_q, prev_state_d;
    logic [7:0] wall_x_q, wall_x_d;
    logic [7:0] move_cnt_q, move_cnt_d;
    logic [7:0] base_x_q, base_x_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic [2:0] col_q, col_d;
    logic       pend_q, pend_d;
    logic [2:0] pend_col_q, pend_col_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       touched_q, touched_d;
    logic       busy_q, busy_d;

    logic       entry, req, last, start, row_end, hit;
    logic [2:0] req_col;

    always_comb begin
        sw_d         = sw_q;
        prev_state_d = state;
        wall_x_d     = wall_x_q;
        move_cnt_d   = move_cnt_q;
        base_x_d     = base_x_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        col_d        = col_q;
        pend_d       = pend_q;
        pend_col_d   = pend_col_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        entry        = state != prev_state_q;
        if (entry && state == ST_READY) begin
            wall_x_d   = 8'(START_X);
            move_cnt_d = '0;
        end
        if (entry && state == ST_MOVE) begin
            move_cnt_d = (move_cnt_q == 8'(MOVE_DIV - 1)) ? '0 : move_cnt_q + 8'd1;
            if (move_cnt_q == 8'(MOVE_DIV - 1))
                wall_x_d = (wall_x_q < 8'(STEP)) ? '0 : wall_x_q - 8'(STEP);
        end
        req     = entry && (state == ST_DRAW || state == ST_DEL);
        req_col = (state == ST_DRAW) ? WALL_COL : BG_COL;
        row_end = cx_q == 8'(WALL_W - 1);
        last    = sw_q == S_RUN && row_end && cy_q == 7'(WALL_H - 1);
        // Emit the current pixel while running, then advance in raster order.
        plot_d = sw_q == S_RUN;
        if (sw_q == S_RUN) begin
            x_d      = base_x_q + cx_q;
            y_d      = 7'(WALL_Y) + cy_q;
            colour_d = col_q;
            cx_d     = row_end ? '0 : cx_q + 8'd1;
            cy_d     = row_end ? cy_q + 7'd1 : cy_q;
        end
        // A sweep can start when idle or on its predecessor's last pixel, so a
        // queued request follows with no plot gap; a fresh request beats the slot.
        start = (sw_q == S_IDLE || last) && (req || pend_q);
        if (sw_q == S_RUN && !last && req) begin
            pend_d     = 1'b1;
            pend_col_d = req_col;
        end
        if (start) begin
            sw_d     = S_RUN;
            base_x_d = wall_x_q;
            col_d    = req ? req_col : pend_col_q;
            cx_d     = '0;
            cy_d     = '0;
            pend_d   = 1'b0;
        end else if (last) begin
            sw_d = S_IDLE;
        end
        busy_d = (sw_d == S_RUN) | pend_d;
        hit = ({1'b0, wall_x_q} < {1'b0, player_x} + 9'(PLAYER_W)) &&
              ({1'b0, player_x} < {1'b0, wall_x_q} + 9'(WALL_W)) &&
              (9'(WALL_Y) < {2'b0, player_y} + 9'(PLAYER_H)) &&
              ({2'b0, player_y} < 9'(WALL_Y + WALL_H));
        touched_d = (entry && state == ST_READY) ? 1'b0 : touched_q | hit | (wall_x_q == 8'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_q         <= S_IDLE;
            prev_state_q <= '0;
            wall_x_q     <= 8'(START_X);
            move_cnt_q   <= '0;
            base_x_q     <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            col_q        <= '0;
            pend_q       <= 1'b0;
            pend_col_q   <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            touched_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sw_q         <= sw_d;
            prev_state_q <= prev_state_d;
            wall_x_q     <= wall_x_d;
            move_cnt_q   <= move_cnt_d;
            base_x_q     <= base_x_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            col_q        <= col_d;
            pend_q       <= pend_d;
            pend_col_q   <= pend_col_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            touched_q    <= touched_d;
            busy_q       <= busy_d;
        end
    end

    assign vga.x_out  = x_q;
    assign vga.y_out  = y_q;
    assign vga.colour = colour_q;
    assign vga.plot   = plot_q;
    assign touched    = touched_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_wall_datapath.sv
// tb_wall_datapath: directed stimulus with a pixel scoreboard for wall_datapath
module tb_wall_datapath;
    localparam logic [3:0] READY = 4'b0101, MOVE = 4'b0110, STOP = 4'b0111;
    localparam logic [3:0] DRAW = 4'b1000, DEL = 4'b1001, UPDATE = 4'b1010;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state;
    logic [7:0] player_x;
    logic [6:0] player_y;
    logic       touched, busy;
    wall_vga_if vga();

    wall_datapath dut (
        .clk(clk), .reset(reset), .state(state), .player_x(player_x), .player_y(player_y),
        .vga(vga), .touched(touched), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [17:0] q[$];
    int applied = 0, miscompares = 0, gaps = 0;
    logic prev_plot = 1'b0;

    always @(negedge clk) begin
        logic [17:0] e;
        if (reset) prev_plot = 1'b0;
        else begin
            if (prev_plot && !vga.plot && q.size() != 0) gaps++;
            if (vga.plot) begin
                applied++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pixel_unexpected got x=%0d y=%0d c=%0d, none expected", vga.x_out, vga.y_out, vga.colour);
                end else begin
                    e = q.pop_front();
                    if ({vga.x_out, vga.y_out, vga.colour} !== e) begin
                        miscompares++;
                        $display("FAIL pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                                 vga.x_out, vga.y_out, vga.colour, e[17:10], e[9:3], e[2:0]);
                    end
                    applied++;
                    if (busy !== (q.size() != 0)) begin
                        miscompares++;
                        $display("FAIL busy_track got %0b want %0b", busy, q.size() != 0);
                    end
                end
            end
            prev_plot = vga.plot;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [3:0] s);
        state = s;
        cyc(1);
    endtask

    task automatic move_entry(input int n);
        for (int i = 0; i < n; i++) begin
            go(MOVE);
            go(UPDATE);
        end
    endtask

    task automatic push_sweep(input int bx, input logic [2:0] col);
        for (int cy = 0; cy < 40; cy++)
            for (int cx = 0; cx < 4; cx++)
                q.push_back({8'(bx + cx), 7'(60 + cy), col});
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({nm, "_drain"}, q.size(), 0);
        cyc(2);
        chk({nm, "_plot_low"}, int'(vga.plot), 0);
        chk({nm, "_busy_low"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; state = READY; player_x = 8'd200; player_y = 7'd0;
        cyc(2);
        chk("rst_x", int'(vga.x_out), 0);
        chk("rst_y", int'(vga.y_out), 0);
        chk("rst_colour", int'(vga.colour), 0);
        chk("rst_plot", int'(vga.plot), 0);
        chk("rst_touched", int'(touched), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        cyc(3);
        // 1: first draw at START_X
        push_sweep(150, 3'b111);
        go(DRAW);
        chk("t1_plot_latency", int'(vga.plot), 0);
        cyc(1);
        chk("t1_first_plot", int'(vga.plot), 1);
        chk("t1_busy", int'(busy), 1);
        drain("t1");
        // 2: eight move entries -> 148
        move_entry(8);
        chk("t2_touched", int'(touched), 0);
        push_sweep(148, 3'b111);
        go(DRAW);
        drain("t2");
        // 3: DEL then DRAW two cycles apart, back to back
        gaps = 0;
        push_sweep(148, 3'b000);
        push_sweep(148, 3'b111);
        go(DEL);
        cyc(1);
        go(DRAW);
        drain("t3");
        chk("t3_no_gap", gaps, 0);
        // 4: wall moves into a player at (140,70)
        player_x = 8'd140; player_y = 7'd70;
        move_entry(19);
        chk("t4_no_touch_144", int'(touched), 0);
        go(MOVE);
        chk("t4_touch_not_yet", int'(touched), 0);
        cyc(1);
        chk("t4_touch_set", int'(touched), 1);
        go(STOP);
        cyc(3);
        chk("t4_touch_stop", int'(touched), 1);
        go(READY);
        chk("t4_touch_clear", int'(touched), 0);
        player_x = 8'd200; player_y = 7'd0;
        // 5: reset in the middle of a sweep
        push_sweep(150, 3'b111);
        go(DRAW);
        n = 0;
        while (q.size() > 110 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("t5_reach_px50", int'(q.size() <= 110), 1);
        #3 reset = 1'b1;
        #1;
        chk("t5_plot_async", int'(vga.plot), 0);
        chk("t5_busy_async", int'(busy), 0);
        q.delete();
        state = READY;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        push_sweep(150, 3'b111);
        go(DRAW);
        drain("t5");
        // 6: drive the wall to the left edge
        move_entry(596);
        chk("t6_touch_at1", int'(touched), 0);
        move_entry(4);
        chk("t6_touch_at0", int'(touched), 1);
        move_entry(8);
        chk("t6_touch_held", int'(touched), 1);
        push_sweep(0, 3'b111);
        go(DRAW);
        drain("t6");
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
